uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, meaning the number of byte-stream requesters (legal range 1..8).
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 2000000, meaning the stall limit in sys_clk cycles before a held grant is revoked (10 ms at 200 MHz; must be >= 2).
REQ-003 The module SHALL have port sys_clk  input  1  system clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 The module SHALL have port req_data  input  NUM_REQ*8  requester bytes; requester i occupies bits [8i+7:8i].
REQ-006 The module SHALL have port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 The module SHALL have port req_last  input  NUM_REQ  per-requester last-byte-of-message flag, qualified by req_valid.
REQ-008 The module SHALL have port req_ready  output  NUM_REQ  per-requester byte accept.
REQ-009 The module SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-010 The module SHALL have port tx_data_valid  output  1  byte valid to the UART transmitter.
REQ-011 The module SHALL have port tx_data_ready  input  1  UART transmitter ready.
REQ-012 The module SHALL have port grant  output  NUM_REQ  one-hot current owner; all-zero when none.
REQ-013 The module SHALL have port busy  output  1  high while in XFER or while tx_data_valid is high.
REQ-014 The module SHALL have port timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 The module SHALL implement exactly two states, IDLE and XFER; grant is all-zero in IDLE and one-hot in XFER.
REQ-016 In IDLE with any req_valid high, the module SHALL register grant for the first requester with req_valid high, searching round-robin from index (last_owner+1) mod NUM_REQ, and SHALL enter XFER on the next edge.
REQ-017 In IDLE with no req_valid high, the module SHALL remain in IDLE, with all outputs unchanged except busy tracking tx_data_valid.
REQ-018 The module SHALL drive req_ready[i] = grant[i] AND (NOT tx_data_valid OR tx_data_ready) combinationally; all other req_ready bits are 0.
REQ-019 A byte SHALL be accepted when req_valid[i] and req_ready[i] are both high; on that edge tx_data loads req_data[i] and tx_data_valid is set.
REQ-020 The module SHALL hold tx_data and tx_data_valid stable until tx_data_ready is high; on acceptance with no new load, tx_data_valid clears.
REQ-021 When a new byte is loaded on the same edge that the UART accepts the previous byte, the module SHALL keep tx_data_valid high with no bubble.
REQ-022 Latency SHALL be: req_valid rises in IDLE at cycle 0 -> grant at cycle 1 -> req_ready at cycle 1 if the buffer is free -> tx_data_valid at cycle 2.
REQ-023 On acceptance of a byte with req_last high, the module SHALL set last_owner to the granted index, clear grant, and enter IDLE.
REQ-024 After a release, IDLE SHALL last at least one cycle, so no back-to-back grant occurs in the release cycle.
REQ-025 The module SHALL not interleave bytes of different requesters within a message; grant holds until req_last or timeout.
REQ-026 In XFER, the stall counter SHALL clear on every accepted byte, hold its value while the granted req_valid is high but blocked, and increment while the granted req_valid is low.
REQ-027 When the stall counter reaches TIMEOUT_CYCLES-1 in XFER, the module SHALL clear grant, set last_owner, pulse timeout_pulse for one cycle, enter IDLE, and clear the counter.
REQ-028 A byte already in tx_data SHALL still be delivered after a release or timeout; a newly granted requester waits via req_ready until the buffer is free.
REQ-029 The round-robin pointer SHALL be ceil(log2(NUM_REQ)) bits wide, with a minimum of 1, and SHALL wrap from NUM_REQ-1 to 0.
REQ-030 The stall counter SHALL be 32 bits wide and SHALL not wrap.

Reset
REQ-031 While rst_n is low at a clock edge, the module SHALL set state=IDLE, grant=0, tx_data=8'd0, tx_data_valid=0, timeout_pulse=0, stall counter=0, and last_owner=NUM_REQ-1, so that requester 0 has first priority.
REQ-032 Reset asserted mid-message SHALL discard any buffered byte and in-progress grant; no partial byte is emitted after reset release.
REQ-033 Reset SHALL take effect only on a clock edge; asynchronous glitches on rst_n SHALL have no effect between edges.

Verification
REQ-034 The bench SHALL cover: requester 1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with tx_data_ready always high -> grant=0010 at cycle 1, tx_data sequence 41,42,43, grant=0000 after 0x43.
REQ-035 The bench SHALL cover: all 4 requesters hold single-byte messages (last=1) continuously after reset -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-036 The bench SHALL cover: tx_data_ready low for 20 cycles during requester 0's message -> tx_data and tx_data_valid stable throughout, no byte lost or duplicated, and no timeout.
REQ-037 The bench SHALL cover: TIMEOUT_CYCLES=16, requester 2 sends one byte without last and then drops valid -> timeout_pulse high exactly once, 16 cycles after the last acceptance, then grant=0000.
REQ-038 The bench SHALL cover: rst_n low for 1 cycle while tx_data_valid=1 mid-message -> next cycle tx_data_valid=0, grant=0000, and requester 0 wins the next arbitration.
REQ-039 The bench SHALL cover: requester 3 sends last byte while requester 0 waits and the UART is blocked -> requester 0 is granted, its req_ready stays 0 until the requester 3 byte is accepted, then its byte follows with no gap.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter merging NUM_REQ byte-message streams into one UART byte stream, with stall timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_pulse
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [31:0] STALL_MAX = 32'(TIMEOUT_CYCLES - 1);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_n;
  logic [PW-1:0] owner, owner_n, last_owner, last_owner_n, sel, cand;
  logic [NUM_REQ-1:0] grant_n;
  logic [31:0] stall, stall_n;
  logic [7:0] tx_data_n, byte_sel;
  logic tx_data_valid_n, timeout_n, any, accept, rel;
  assign req_ready = grant & {NUM_REQ{~tx_data_valid | tx_data_ready}};
  assign accept = |(req_valid & req_ready);
  assign busy = state == XFER || tx_data_valid;
  always_comb begin
    sel = last_owner;
    cand = '0;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = PW'((int'(last_owner) + k) % NUM_REQ);
      sel = req_valid[cand] ? cand : sel;
      any = any | req_valid[cand];
    end
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    last_owner_n = last_owner;
    stall_n = stall;
    timeout_n = 1'b0;
    rel = 1'b0;
    byte_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) byte_sel = grant[i] ? req_data[i*8 +: 8] : byte_sel;
    tx_data_n = accept ? byte_sel : tx_data;
    tx_data_valid_n = accept || (tx_data_valid && !tx_data_ready);
    if (state == IDLE) begin
      stall_n = '0;
      if (any) begin
        state_n = XFER;
        grant_n = NUM_REQ'(1) << sel;
        owner_n = sel;
      end
    end else begin
      stall_n = accept ? '0 : (req_valid[owner] || stall == '1) ? stall : stall + 32'd1;
      timeout_n = !accept && stall == STALL_MAX;
      rel = (accept && |(req_last & grant)) || timeout_n;
      if (rel) begin
        state_n = IDLE;
        grant_n = '0;
        last_owner_n = owner;
      end
      if (timeout_n) stall_n = '0;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      last_owner <= LAST_IDX;
      stall <= '0;
      tx_data <= '0;
      tx_data_valid <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      owner <= owner_n;
      last_owner <= last_owner_n;
      stall <= stall_n;
      tx_data <= tx_data_n;
      tx_data_valid <= tx_data_valid_n;
      timeout_pulse <= timeout_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with directed scenarios and randomized message traffic for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int TO = 16;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_last = '0;
  logic [N-1:0] req_ready, grant;
  logic [7:0] tx_data;
  logic tx_data_valid, busy, timeout_pulse;
  logic tx_data_ready = 1'b1;
  int checks = 0;
  int errors = 0;
  int to_count = 0;
  logic [7:0] exp_q[$];
  logic [8:0] src_q[N][$];
  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready),
    .grant(grant),
    .busy(busy),
    .timeout_pulse(timeout_pulse)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge sys_clk) begin
    if (timeout_pulse) to_count++;
    if (rst_n && tx_data_valid && tx_data_ready) begin
      if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, tx_data}, 32'hffff_ffff);
      else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
  end
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic set_req(int i, logic v, logic [7:0] d, logic l);
    req_valid[i] = v;
    req_data[i*8 +: 8] = d;
    req_last[i] = l;
  endtask
  task automatic do_reset();
    chk("drained", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b0;
    req_valid = '0;
    req_last = '0;
    tx_data_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic serve(int i);
    logic f;
    int n = 0;
    do begin
      @(negedge sys_clk);
      f = req_valid[i] & req_ready[i];
      @(posedge sys_clk);
      #1;
      n++;
    end while (!f && n < 100);
    chk($sformatf("serve%0d", i), {31'd0, f}, 1);
  endtask
  function automatic int src_left();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction
  task automatic build_traffic();
    logic [8:0] mq[N][$];
    logic [8:0] it;
    int ptr = N - 1;
    bit found;
    for (int i = 0; i < N; i++) begin
      int m = $urandom_range(1, 4);
      for (int a = 0; a < m; a++) begin
        int len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          it = {b == len - 1, 2'(i), 6'($urandom)};
          src_q[i].push_back(it);
          mq[i].push_back(it);
        end
      end
    end
    for (int msg = 0; msg < 64; msg++) begin
      found = 0;
      for (int k = 1; k <= N && !found; k++) begin
        int j = (ptr + k) % N;
        if (mq[j].size() != 0) begin
          found = 1;
          ptr = j;
          do begin
            it = mq[j].pop_front();
            exp_q.push_back(it[7:0]);
          end while (!it[8]);
        end
      end
    end
  endtask
  task automatic run_random();
    logic [N-1:0] f;
    int gap[N];
    bit mid[N];
    int cyc = 0;
    int t0 = to_count;
    for (int i = 0; i < N; i++) begin
      gap[i] = 0;
      mid[i] = 0;
    end
    while (src_left() != 0 && cyc < 3000) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() == 0) set_req(i, 0, 8'd0, 0);
        else if (mid[i] && gap[i] < 3 && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b0;
          gap[i]++;
        end else set_req(i, 1, src_q[i][0][7:0], src_q[i][0][8]);
      end
      tx_data_ready = $urandom_range(0, 9) < 7;
      @(negedge sys_clk);
      f = req_valid & req_ready;
      @(posedge sys_clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) if (f[i]) begin
        mid[i] = !src_q[i][0][8];
        void'(src_q[i].pop_front());
        gap[i] = 0;
      end
    end
    chk("rand_sources_done", src_left(), 0);
    req_valid = '0;
    tx_data_ready = 1'b1;
    repeat (4) tick();
    chk("rand_no_timeout", to_count - t0, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n, t0;
    logic ok;
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_valid", tx_data_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_pulse, 0);
    chk("rst_ready", req_ready, 0);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    set_req(1, 1, 8'h41, 0);
    tick();
    chk("msg_grant", grant, 4'b0010);
    chk("msg_ready", req_ready, 4'b0010);
    chk("msg_busy", busy, 1);
    tick();
    chk("msg_b0", tx_data, 8'h41);
    set_req(1, 1, 8'h42, 0);
    tick();
    chk("msg_b1", tx_data, 8'h42);
    set_req(1, 1, 8'h43, 1);
    tick();
    chk("msg_b2", tx_data, 8'h43);
    chk("msg_release", grant, 0);
    set_req(1, 0, 8'd0, 0);
    tick();
    chk("msg_empty", tx_data_valid, 0);
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 8'(8'hA0 + i), 1);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'hA0 + i % 4));
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("rr_grant%0d", k), grant, (k % 2) ? (1 << (((k - 1) / 2) % 4)) : 0);
    end
    req_valid = '0;
    tick();
    tick();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    t0 = to_count;
    set_req(0, 1, 8'h10, 0);
    tick();
    chk("stall_grant", grant, 4'b0001);
    tick();
    set_req(0, 1, 8'h11, 0);
    tx_data_ready = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      tick();
      ok &= tx_data == 8'h10 && tx_data_valid && !timeout_pulse && req_ready == 0;
    end
    chk("stall_hold", ok, 1);
    tx_data_ready = 1'b1;
    #1;
    chk("stall_ready", req_ready, 4'b0001);
    tick();
    chk("stall_b1", tx_data, 8'h11);
    chk("stall_nobubble", tx_data_valid, 1);
    set_req(0, 1, 8'h12, 1);
    tick();
    chk("stall_b2", tx_data, 8'h12);
    set_req(0, 0, 8'd0, 0);
    tick();
    chk("stall_no_timeout", to_count - t0, 0);
    t0 = to_count;
    exp_q.push_back(8'h77);
    set_req(2, 1, 8'h77, 0);
    serve(2);
    set_req(2, 0, 8'd0, 0);
    n = 0;
    while (!timeout_pulse && n < 40) begin
      tick();
      n++;
    end
    chk("to_delay", n, 16);
    chk("to_grant", grant, 0);
    tick();
    chk("to_pulse_width", timeout_pulse, 0);
    tick();
    chk("to_once", to_count - t0, 1);
    set_req(3, 1, 8'h99, 0);
    tick();
    chk("rs_grant", grant, 4'b1000);
    tx_data_ready = 1'b0;
    tick();
    chk("rs_buffered", tx_data_valid, 1);
    set_req(3, 1, 8'h9A, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs_valid", tx_data_valid, 0);
    chk("rs_grant0", grant, 0);
    tx_data_ready = 1'b1;
    set_req(0, 1, 8'h01, 1);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h9A);
    tick();
    chk("rs_winner", grant, 4'b0001);
    tick();
    set_req(0, 0, 8'd0, 0);
    serve(3);
    set_req(3, 0, 8'd0, 0);
    tick();
    tick();
    set_req(2, 1, 8'h22, 1);
    exp_q.push_back(8'h22);
    serve(2);
    set_req(2, 0, 8'd0, 0);
    set_req(3, 1, 8'h33, 1);
    set_req(0, 1, 8'h30, 1);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h30);
    serve(3);
    set_req(3, 0, 8'd0, 0);
    tx_data_ready = 1'b0;
    tick();
    chk("bl_grant", grant, 4'b0001);
    ok = 1'b1;
    repeat (5) begin
      ok &= req_ready == 0 && tx_data == 8'h33 && tx_data_valid;
      tick();
    end
    chk("bl_wait", ok, 1);
    tx_data_ready = 1'b1;
    #1;
    chk("bl_ready", req_ready, 4'b0001);
    tick();
    chk("bl_nogap", tx_data_valid, 1);
    chk("bl_next", tx_data, 8'h30);
    set_req(0, 0, 8'd0, 0);
    tick();
    tick();
    repeat (3) begin
      do_reset();
      build_traffic();
      run_random();
    end
    chk("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
